// File: rtl/mac_accum.sv
// mac_accum: sums a counted run of unsigned products, then holds the total until the consumer takes it.
module mac_accum #(
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                start,
    input  logic [CNT_W-1:0]    n_terms,
    input  logic [14:0]         prod,
    input  logic                prod_valid,
    output logic                prod_ready,
    output logic [CNT_W+14:0]   acc_out,
    output logic                acc_valid,
    input  logic                acc_ready,
    output logic                busy
);
    localparam int ACC_W = 15 + CNT_W;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, n_lat;
    logic beat, last;
    assign prod_ready = state == ACCUM;
    assign acc_valid  = state == DONE;
    assign busy       = state != IDLE;
    assign beat       = prod_ready & prod_valid;
    // n_lat of 0 wraps to all-ones here, giving the full 2^CNT_W run
    assign last       = cnt == n_lat - 1'b1;
    always_comb begin
        state_nx = state;
        state_nx = clear                       ? IDLE  :
                   (state == IDLE && start)    ? ACCUM :
                   (beat && last)              ? DONE  :
                   (state == DONE && acc_ready) ? IDLE  : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc_out <= '0;
            cnt     <= '0;
            n_lat   <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                acc_out <= '0;
                cnt     <= '0;
            end else if (state == IDLE && start) begin
                acc_out <= '0;
                cnt     <= '0;
                n_lat   <= n_terms;
            end else if (beat) begin
                acc_out <= acc_out + ACC_W'(prod);
                cnt     <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed vectors with a scoreboard of expected sums checked by an output monitor.
module tb_mac_accum;
    logic        clk = 0;
    logic        rst_n = 1;
    logic        clear = 0;
    logic        start = 0;
    logic [3:0]  n_terms = '0;
    logic [14:0] prod = '0;
    logic        prod_valid = 0;
    logic        prod_ready;
    logic [18:0] acc_out;
    logic        acc_valid;
    logic        acc_ready = 0;
    logic        busy;
    int checks = 0;
    int errors = 0;
    int beats = 0;
    int held = 0;
    logic prev_valid = 0;
    int sb[$];
    mac_accum #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .n_terms(n_terms),
        .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic go(int n);
        start = 1;
        n_terms = 4'(n);
        beats = 0;
        step();
        start = 0;
    endtask
    task automatic send(int p);
        prod = 15'(p);
        prod_valid = 1;
        for (int i = 0; i < 50 && !prod_ready; i++) step();
        chk("send_ready", int'(prod_ready), 1);
        step();
        prod_valid = 0;
    endtask
    task automatic take();
        acc_ready = 1;
        step();
        acc_ready = 0;
    endtask
    // monitor: pops on each new presentation, then requires acc_out to hold while valid
    always @(negedge clk) begin
        if (prod_valid && prod_ready) beats++;
        if (acc_valid && !prev_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", int'(acc_out), -1);
            else chk("acc_out", int'(acc_out), sb.pop_front());
            held = int'(acc_out);
        end else if (acc_valid) begin
            chk("acc_hold", int'(acc_out), held);
        end
        prev_valid = acc_valid;
    end
    initial begin
        #2 rst_n = 0;
        #10;
        chk("rst_acc_out", int'(acc_out), 0);
        chk("rst_acc_valid", int'(acc_valid), 0);
        chk("rst_prod_ready", int'(prod_ready), 0);
        chk("rst_busy", int'(busy), 0);
        step();
        rst_n = 1;
        step();
        step();
        chk("post_rst_idle", int'(busy), 0);
        // single full-scale product
        sb.push_back(32385);
        go(1);
        send(32385);
        chk("t1_valid", int'(acc_valid), 1);
        take();
        chk("t1_busy", int'(busy), 0);
        chk("t1_valid_low", int'(acc_valid), 0);
        chk("t1_keep", int'(acc_out), 32385);
        // n_terms=0 means 16 beats, worst-case sum
        sb.push_back(518160);
        go(0);
        for (int i = 0; i < 16; i++) send(32385);
        chk("t2_ready_low", int'(prod_ready), 0);
        chk("t2_valid", int'(acc_valid), 1);
        prod_valid = 1;
        step();
        step();
        prod_valid = 0;
        chk("t2_beats", beats, 16);
        take();
        // bubbles and consumer back-pressure
        sb.push_back(6);
        go(3);
        for (int b = 1; b <= 3; b++) begin
            send(b);
            if (b < 3) begin
                step();
                step();
            end
        end
        prod_valid = 1;
        prod = 15'd99;
        for (int i = 0; i < 5; i++) step();
        prod_valid = 0;
        chk("t3_valid", int'(acc_valid), 1);
        chk("t3_acc", int'(acc_out), 6);
        chk("t3_beats", beats, 3);
        take();
        // clear aborts a run
        go(4);
        send(100);
        send(200);
        clear = 1;
        step();
        clear = 0;
        chk("clr_acc", int'(acc_out), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_ready", int'(prod_ready), 0);
        chk("clr_valid", int'(acc_valid), 0);
        sb.push_back(30);
        go(2);
        send(10);
        send(20);
        take();
        // start ignored while accumulating and on the handshake cycle
        sb.push_back(3);
        go(2);
        send(1);
        start = 1;
        n_terms = 4'd5;
        step();
        start = 0;
        send(2);
        chk("t5_done", int'(acc_valid), 1);
        start = 1;
        n_terms = 4'd1;
        acc_ready = 1;
        step();
        start = 0;
        acc_ready = 0;
        chk("t5_idle", int'(busy), 0);
        step();
        chk("t5_no_run", int'(busy), 0);
        // asynchronous reset while holding a result
        sb.push_back(30);
        go(2);
        send(10);
        send(20);
        #6;
        rst_n = 0;
        #1;
        chk("arst_valid", int'(acc_valid), 0);
        chk("arst_acc", int'(acc_out), 0);
        chk("arst_busy", int'(busy), 0);
        step();
        rst_n = 1;
        step();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
